// File: rtl/instr_mem_responder.sv
// Instruction-memory responder for the fetch interface.
// Accepts byte-addressed fetch requests through a valid/ready handshake. It
// returns instruction words in request order after LATENCY cycles through a
// second valid/ready handshake. Misaligned or out-of-range fetches return
// NOP_WORD with rsp_err set. A load port writes words into the memory.
//
// Ports:
//   clk, reset            clock; synchronous active-high reset
//   req_valid/req_ready   request handshake; req_addr is the byte address
//   rsp_valid/rsp_ready   response handshake
//   rsp_instr/rsp_addr    returned word and the byte address it belongs to
//   rsp_err               misaligned or out-of-range fetch
//   load_en/addr/data     word write into the memory (also works during reset)
module instr_mem_responder #(
  parameter int          ADDR_WIDTH = 32,
  parameter int          WORD_DEPTH = 256,
  parameter int          LATENCY    = 1,
  parameter logic [31:0] NOP_WORD   = 32'h0000_0013
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic [ADDR_WIDTH-1:0]         req_addr,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [31:0]                   rsp_instr,
  output logic [ADDR_WIDTH-1:0]         rsp_addr,
  output logic                          rsp_err,
  input  logic                          load_en,
  input  logic [$clog2(WORD_DEPTH)-1:0] load_addr,
  input  logic [31:0]                   load_data
);

  localparam int IW  = $clog2(WORD_DEPTH);
  localparam int CAP = LATENCY + 1;
  localparam int CW  = $clog2(CAP + 1);

  logic [31:0] mem [WORD_DEPTH];

  // In-order queue with the head at slot 0. Each entry gets its read data when
  // it is accepted. Its timer counts down the remaining latency, so one queue
  // acts as both the latency pipeline and the response buffer.
  logic [ADDR_WIDTH-1:0] q_addr  [CAP];
  logic [31:0]           q_instr [CAP];
  logic                  q_err   [CAP];
  logic [2:0]            q_tmr   [CAP];
  logic [CW-1:0]         count;

  logic          push;
  logic          pop;
  logic          req_err;
  logic [IW-1:0] req_idx;
  logic [31:0]   req_word;
  logic [CW-1:0] wpos;

  always_comb begin
    req_idx   = req_addr[IW+1:2];
    req_err   = (req_addr[1:0] != 2'b00) ||
                ((req_addr >> 2) >= ADDR_WIDTH'(WORD_DEPTH));
    req_word  = req_err ? NOP_WORD : mem[req_idx];
    req_ready = !reset && (count < CW'(CAP));
    rsp_valid = (count != '0) && (q_tmr[0] == '0);
    push      = req_valid && req_ready;
    pop       = rsp_valid && rsp_ready;
    // Slot for the new entry once the head has shifted out.
    wpos      = count - CW'(pop);
    rsp_instr = rsp_valid ? q_instr[0] : '0;
    rsp_addr  = rsp_valid ? q_addr[0]  : '0;
    rsp_err   = rsp_valid ? q_err[0]   : 1'b0;
  end

  // The memory has no reset. A same-edge read sees the old word.
  always_ff @(posedge clk) begin
    if (load_en) mem[load_addr] <= load_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
      for (int unsigned i = 0; i < CAP; i++) begin
        q_addr[i]  <= '0;
        q_instr[i] <= '0;
        q_err[i]   <= 1'b0;
        q_tmr[i]   <= '0;
      end
    end else begin
      if (pop) begin
        for (int unsigned i = 0; i < CAP - 1; i++) begin
          q_addr[i]  <= q_addr[i+1];
          q_instr[i] <= q_instr[i+1];
          q_err[i]   <= q_err[i+1];
          q_tmr[i]   <= (q_tmr[i+1] != '0) ? q_tmr[i+1] - 3'd1 : '0;
        end
        q_addr[CAP-1]  <= '0;
        q_instr[CAP-1] <= '0;
        q_err[CAP-1]   <= 1'b0;
        q_tmr[CAP-1]   <= '0;
      end else begin
        for (int unsigned i = 0; i < CAP; i++) begin
          if (q_tmr[i] != '0) q_tmr[i] <= q_tmr[i] - 3'd1;
        end
      end
      // This assignment comes after the shift above, so it takes precedence
      // for the slot it writes.
      if (push) begin
        for (int unsigned i = 0; i < CAP; i++) begin
          if (CW'(i) == wpos) begin
            q_addr[i]  <= req_addr;
            q_instr[i] <= req_word;
            q_err[i]   <= req_err;
            q_tmr[i]   <= 3'(LATENCY - 1);
          end
        end
      end
      count <= count + CW'(push) - CW'(pop);
    end
  end

endmodule

// File: tb/tb_instr_mem_responder.sv
module tb_instr_mem_responder;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        rsp_ready = 1'b0;
  logic        load_en = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] load_data = '0;
  logic [7:0]  load_addr = '0;

  logic        req_ready_a, rsp_valid_a, rsp_err_a;
  logic [31:0] rsp_instr_a, rsp_addr_a;
  logic        req_ready_b, rsp_valid_b, rsp_err_b;
  logic [31:0] rsp_instr_b, rsp_addr_b;

  always #5 clk = ~clk;

  instr_mem_responder #(.ADDR_WIDTH(32), .WORD_DEPTH(256), .LATENCY(1),
                        .NOP_WORD(32'h0000_0013)) u_a (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready_a), .req_addr(req_addr),
    .rsp_valid(rsp_valid_a), .rsp_ready(rsp_ready),
    .rsp_instr(rsp_instr_a), .rsp_addr(rsp_addr_a), .rsp_err(rsp_err_a),
    .load_en(load_en), .load_addr(load_addr), .load_data(load_data));

  instr_mem_responder #(.ADDR_WIDTH(32), .WORD_DEPTH(256), .LATENCY(3),
                        .NOP_WORD(32'h0000_0013)) u_b (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready_b), .req_addr(req_addr),
    .rsp_valid(rsp_valid_b), .rsp_ready(rsp_ready),
    .rsp_instr(rsp_instr_b), .rsp_addr(rsp_addr_b), .rsp_err(rsp_err_b),
    .load_en(load_en), .load_addr(load_addr), .load_data(load_data));

  // Reference model: a list of outstanding fetches per instance. Each entry
  // records the edge count after which its response becomes visible.
  typedef struct {
    logic [31:0] addr;
    logic [31:0] instr;
    logic        err;
    int          due;
  } ent_t;

  ent_t        mq[2][$];
  logic [31:0] mem_m[256];
  int          lat[2] = '{1, 3};
  bit          ev[2];
  bit          er[2];
  int          cyc = 0;
  int          checks = 0;
  int          failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h (edge %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic check_outputs();
    for (int d = 0; d < 2; d++) begin
      logic [31:0] o_v, o_r, o_i, o_a, o_e, o_c;
      logic [31:0] e_i, e_a, e_e;
      string       p;
      if (d == 0) begin
        o_v = 32'(rsp_valid_a); o_r = 32'(req_ready_a); o_i = rsp_instr_a;
        o_a = rsp_addr_a; o_e = 32'(rsp_err_a); o_c = 32'(u_a.count);
      end else begin
        o_v = 32'(rsp_valid_b); o_r = 32'(req_ready_b); o_i = rsp_instr_b;
        o_a = rsp_addr_b; o_e = 32'(rsp_err_b); o_c = 32'(u_b.count);
      end
      ev[d] = (mq[d].size() > 0) && (cyc >= mq[d][0].due);
      er[d] = !reset && (mq[d].size() < lat[d] + 1);
      e_i = ev[d] ? mq[d][0].instr : '0;
      e_a = ev[d] ? mq[d][0].addr  : '0;
      e_e = ev[d] ? 32'(mq[d][0].err) : '0;
      p = $sformatf("L%0d.", lat[d]);
      check({p, "rsp_valid"}, o_v, 32'(ev[d]));
      check({p, "req_ready"}, o_r, 32'(er[d]));
      check({p, "rsp_instr"}, o_i, e_i);
      check({p, "rsp_addr"},  o_a, e_a);
      check({p, "rsp_err"},   o_e, e_e);
      check({p, "count_le_cap"}, 32'(o_c <= 32'(lat[d] + 1)), 32'd1);
      check({p, "count"}, o_c, 32'(mq[d].size()));
    end
  endtask

  task automatic model_update();
    cyc++;
    for (int d = 0; d < 2; d++) begin
      if (reset) begin
        mq[d].delete();
      end else begin
        if (ev[d] && rsp_ready) void'(mq[d].pop_front());
        if (er[d] && req_valid) begin
          ent_t e;
          e.addr  = req_addr;
          e.err   = (req_addr % 4 != 0) || (req_addr / 4 >= 256);
          e.instr = e.err ? 32'h0000_0013 : mem_m[req_addr / 4];
          e.due   = cyc + lat[d] - 1;
          mq[d].push_back(e);
        end
      end
    end
    if (load_en) mem_m[load_addr] = load_data;
  endtask

  task automatic step(input bit v, input logic [31:0] a, input bit r, input bit rs);
    req_valid = v;
    req_addr  = a;
    rsp_ready = r;
    reset     = rs;
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    model_update();
    #1;
    load_en = 1'b0;
  endtask

  task automatic idle(input int n, input bit r);
    for (int i = 0; i < n; i++) step(1'b0, 32'h0, r, 1'b0);
  endtask

  logic [31:0] init4[4] = '{32'h0050_0093, 32'h0010_0113, 32'h0020_81B3, 32'h0000_0013};

  initial begin
    @(posedge clk);
    #1;
    // Fill words 0..15 while reset is held.
    for (int i = 0; i < 16; i++) begin
      load_en   = 1'b1;
      load_addr = 8'(i);
      load_data = (i < 4) ? init4[i] : $urandom;
      step(1'b0, 32'h0, 1'b0, 1'b1);
    end
    idle(1, 1'b1);

    // Streaming read of four consecutive words.
    for (int i = 0; i < 4; i++) step(1'b1, 32'(i * 4), 1'b1, 1'b0);
    idle(5, 1'b1);

    // Backpressure followed by a drain.
    for (int i = 0; i < 6; i++) step(1'b1, 32'(i * 4), 1'b0, 1'b0);
    idle(7, 1'b1);

    // Misaligned fetch, out-of-range fetch, then a good fetch.
    step(1'b1, 32'h6, 1'b1, 1'b0);
    step(1'b1, 32'h400, 1'b1, 1'b0);
    step(1'b1, 32'h4, 1'b1, 1'b0);
    idle(5, 1'b1);

    // Reset with two requests outstanding; memory survives.
    step(1'b1, 32'h0, 1'b0, 1'b0);
    step(1'b1, 32'h4, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b0, 1'b0);
    step(1'b1, 32'h8, 1'b0, 1'b1);
    idle(2, 1'b0);
    step(1'b1, 32'h0, 1'b1, 1'b0);
    idle(5, 1'b1);

    // Load and fetch of the same word in one cycle.
    load_en = 1'b1; load_addr = 8'd1; load_data = 32'hDEAD_BEEF;
    step(1'b1, 32'h4, 1'b1, 1'b0);
    step(1'b1, 32'h4, 1'b1, 1'b0);
    idle(5, 1'b1);

    // Random traffic.
    for (int n = 0; n < 600; n++) begin
      logic [31:0] a;
      case ($urandom % 8)
        0:       a = (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(1, 3));
        1:       a = ($urandom & 32'hFFFF_FFFC) | 32'h0000_0400;
        default: a = 32'($urandom_range(0, 15)) << 2;
      endcase
      if ($urandom % 10 == 0) begin
        load_en   = 1'b1;
        load_addr = 8'($urandom_range(0, 15));
        load_data = $urandom;
      end
      step(($urandom % 4) != 0, a, ($urandom % 10) < 7, ($urandom % 50) == 0);
    end
    idle(6, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instr_mem_responder.md
Name: instr_mem_responder

Overview:
- Instruction-memory side of the fetch interface. It takes fetch addresses driven by the program counter and returns instruction words.
- Word-organised internal storage; a configurable read latency; valid/ready handshakes on both the request and response sides.
- Returns responses in order; flags misaligned and out-of-range fetches.
- Sits between the PC/fetch stage and decode. A load port fills the memory before execution.

Parameters:
- ADDR_WIDTH, 32, width of the byte address on req_addr/rsp_addr.
- WORD_DEPTH, 256, number of 32-bit words stored (power of two, ≥ 4).
- LATENCY, 1, cycles from request accept to earliest response valid (legal 1..4).
- NOP_WORD, 32'h00000013, instruction returned on error responses.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  fetch request present.
- req_ready  out  1  responder can accept a request this cycle.
- req_addr  in  ADDR_WIDTH  byte address of the fetch.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts the response.
- rsp_instr  out  32  fetched instruction word.
- rsp_addr  out  ADDR_WIDTH  byte address the response belongs to.
- rsp_err  out  1  misaligned or out-of-range fetch.
- load_en  in  1  write load_data into memory this cycle.
- load_addr  in  log2(WORD_DEPTH)  word index for load.
- load_data  in  32  word to store.

Behaviour:
- Clock and reset:
  - One clock, clk.
  - reset is synchronous and active-high; sampled on the rising edge of clk.
- Reset:
  - Clears the pipeline, response queue and occupancy count.
  - Outputs after reset: rsp_valid=0, rsp_instr=0, rsp_addr=0, rsp_err=0.
  - req_ready=0 in any cycle where reset=1.
  - Memory contents are NOT cleared.
  - In-flight requests are discarded; no response is ever produced for them.
- Request accept:
  - A request is accepted on a rising edge where req_valid && req_ready && !reset.
  - Word index = req_addr[log2(WORD_DEPTH)+1:2].
- Error rules:
  - err = (req_addr[1:0] != 0) || (req_addr >> 2 >= WORD_DEPTH).
  - On err, the response carries rsp_err=1 and rsp_instr=NOP_WORD; memory is not read.
- Latency:
  - A request accepted at edge k has its response visible (rsp_valid=1) in the cycle after edge k+LATENCY-1, i.e. LATENCY cycles after acceptance.
  - This holds provided no older response is still pending.
- Occupancy:
  - CAP = LATENCY+1 entries (in-flight + queued).
  - Counter increments on request accept and decrements on response handshake (rsp_valid && rsp_ready).
  - Simultaneous accept and handshake leave it unchanged.
  - req_ready = !reset && (count < CAP).
  - CAP guarantees full throughput (one per cycle) with rsp_ready held at 1.
  - Overflow is impossible by construction; the bench must assert count never exceeds CAP.
- Ordering and stability:
  - Responses are strictly in request order.
  - While rsp_valid=1 && rsp_ready=0, rsp_instr/rsp_addr/rsp_err stay stable.
  - When rsp_valid=0, rsp_instr/rsp_addr/rsp_err are driven 0.
- Pipeline:
  - Read data is captured into the pipeline at accept (read-before-write).
  - A request does not stall in the pipeline; results land in the queue when they mature.
  - Results are held there until handshaken.
- Load port:
  - Write occurs at the edge where load_en=1, independent of handshakes.
  - A request to the same word in the same cycle returns the OLD word.
  - The following request returns the new word.
  - load_en during reset still writes.
- Handshake rules:
  - The responder never drops rsp_valid without a handshake, except on reset.
  - req_ready may toggle freely.
  - req_addr is sampled only at accept.

Test Plan:
- Streaming read (LATENCY=1):
  - Stimulus: load mem[0..3] = 00500093, 00100113, 002081B3, 00000013; rsp_ready=1; requests at 0x0, 0x4, 0x8, 0xC in consecutive cycles.
  - Required response: rsp_valid first high 1 cycle after the first accept, then 4 consecutive responses with those words, rsp_addr 0x0..0xC, rsp_err=0, req_ready constantly 1.
- Backpressure:
  - Stimulus: rsp_ready=0, req_valid=1 with addresses 0x0, 0x4, 0x8 ...
  - Required response: exactly 2 accepts, then req_ready=0; first response held stable.
  - Then raise rsp_ready: responses 0x0, 0x4 drain in order, req_ready returns to 1, no loss or duplication.
- Errors:
  - req_addr=0x6 → rsp_err=1, rsp_instr=00000013, rsp_addr=0x6.
  - req_addr=0x400 (WORD_DEPTH=256) → rsp_err=1.
  - Next request to 0x4 → rsp_err=0, word 00100113.
- Reset mid-operation:
  - Stimulus: rsp_ready=0 with 2 requests outstanding; 1-cycle reset.
  - Required response: rsp_valid=0 and all outputs 0 after the reset edge; req_ready=0 during reset, 1 after.
  - No stale responses ever appear; re-fetching 0x0 returns 00500093 (memory preserved).
- Load/read collision:
  - Stimulus: load_en writing mem[1]=DEADBEEF in the same cycle as a request to 0x4.
  - Required response: that response returns 00100113; the next fetch of 0x4 returns DEADBEEF.
- LATENCY=3 instance:
  - Stimulus: accept at edge k.
  - Required response: rsp_valid first high 3 cycles after acceptance.
  - With rsp_ready=0, exactly 4 accepts occur before req_ready=0.
  - With rsp_ready=1, sustained 1 response/cycle.
